// File: rtl/cascade_mod_counter.sv
// cascade_mod_counter
//   A chain of DIGITS cascaded digit counters, each modulo RADIX, counting up
//   or down with enable, synchronous clear, parallel load (with per-digit
//   clamping) and optional end-value saturation. Intended for BCD /
//   time-of-day displays and event counting on LED / 7-segment outputs.
//
// Ports
//   clock     in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   en        in   count enable, one step per enabled edge
//   up        in   direction: 1 = increment, 0 = decrement
//   clear     in   synchronous clear (highest priority)
//   load      in   synchronous parallel load
//   load_val  in   load value, digit i at [i*DW +: DW]
//   count     out  registered count, digit 0 least significant
//   digit_tc  out  per-digit end value for the current direction (comb)
//   tc        out  en and every digit at its end value (comb)
//   wrap      out  one-cycle pulse after a full-chain rollover
//   sat       out  chain held at its end value (SATURATE=1 only)
module cascade_mod_counter #(
  parameter int DIGITS   = 4,
  parameter int RADIX    = 10,
  parameter int DW       = 4,
  parameter int SATURATE = 0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   up,
  input  logic                   clear,
  input  logic                   load,
  input  logic [DIGITS*DW-1:0]   load_val,
  output logic [DIGITS*DW-1:0]   count,
  output logic [DIGITS-1:0]      digit_tc,
  output logic                   tc,
  output logic                   wrap,
  output logic                   sat
);

  localparam logic [DW-1:0] DMAX  = DW'(RADIX - 1);
  // One bit wider so RADIX = 2^DW is representable in the clamp compare.
  localparam logic [DW:0]   RAD_W = (DW + 1)'(RADIX);

  logic [DIGITS*DW-1:0] count_q, count_d;
  logic                 wrap_q, wrap_d;
  logic                 sat_q, sat_d;

  logic                 all_end;
  logic                 run;
  logic [DW-1:0]        fld;
  logic [DIGITS*DW-1:0] ld_clamped;
  logic                 ld_end;

  always_comb begin
    digit_tc = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_tc[i] = up ? (count_q[i*DW +: DW] == DMAX)
                       : (count_q[i*DW +: DW] == '0);
    end
  end

  assign all_end = &digit_tc;
  assign tc      = en & all_end;

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    sat_d      = sat_q;
    run        = 1'b1;
    fld        = '0;
    ld_clamped = '0;
    ld_end     = 1'b1;

    // Clamp each load field into range and note whether the clamped value
    // is the end value for the direction in force on the load edge.
    for (int i = 0; i < DIGITS; i++) begin
      fld = load_val[i*DW +: DW];
      if ({1'b0, fld} >= RAD_W) fld = DMAX;
      ld_clamped[i*DW +: DW] = fld;
      ld_end = ld_end & (up ? (fld == DMAX) : (fld == '0));
    end

    if (clear) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (load) begin
      count_d = ld_clamped;
      sat_d   = (SATURATE != 0) && ld_end;
    end else if (en) begin
      if (all_end && (SATURATE != 0)) begin
        sat_d = 1'b1;
      end else begin
        // run stays high while every lower digit sits at its end value,
        // i.e. it is the carry/borrow into digit i.
        for (int i = 0; i < DIGITS; i++) begin
          fld = count_q[i*DW +: DW];
          if (run) begin
            if (up) count_d[i*DW +: DW] = (fld == DMAX) ? '0 : fld + DW'(1);
            else    count_d[i*DW +: DW] = (fld == '0) ? DMAX : fld - DW'(1);
          end
          run = run & digit_tc[i];
        end
        wrap_d = all_end;
        sat_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign sat   = sat_q;

endmodule
